// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and widths for the APB master sequencer.
package apb_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    typedef enum logic {GNT_WR, GNT_RD} grant_t;
    localparam int DEF_TIMEOUT = 16;
    localparam int TO_W = $clog2(DEF_TIMEOUT + 1);
endpackage

// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if: requester handshakes plus APB bus for the master sequencer.
interface apb_master_arb_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
);
    logic                   wr_req_valid, wr_req_ready;
    logic [ADDRWIDTH-1:0]   wr_addr;
    logic [DATAWIDTH-1:0]   wr_data;
    logic [DATAWIDTH/8-1:0] wr_strb;
    logic [2:0]             wr_prot;
    logic                   wr_rsp_valid, wr_rsp_ready, wr_rsp_err;
    logic                   rd_req_valid, rd_req_ready;
    logic [ADDRWIDTH-1:0]   rd_addr;
    logic [2:0]             rd_prot;
    logic                   rd_rsp_valid, rd_rsp_ready, rd_rsp_err;
    logic [DATAWIDTH-1:0]   rd_rsp_data;
    logic                   pselx, penable, pwrite;
    logic [ADDRWIDTH-1:0]   paddr;
    logic [DATAWIDTH-1:0]   pwdata;
    logic [DATAWIDTH/8-1:0] pstrb;
    logic [2:0]             pprot;
    logic                   pready, pslverr;
    logic [DATAWIDTH-1:0]   prdata;
    modport master (
        input  wr_req_valid, wr_addr, wr_data, wr_strb, wr_prot, wr_rsp_ready,
        input  rd_req_valid, rd_addr, rd_prot, rd_rsp_ready, pready, pslverr, prdata,
        output wr_req_ready, wr_rsp_valid, wr_rsp_err, rd_req_ready, rd_rsp_valid, rd_rsp_err,
        output rd_rsp_data, pselx, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
    modport slave (
        output wr_req_valid, wr_addr, wr_data, wr_strb, wr_prot, wr_rsp_ready,
        output rd_req_valid, rd_addr, rd_prot, rd_rsp_ready, pready, pslverr, prdata,
        input  wr_req_ready, wr_rsp_valid, wr_rsp_err, rd_req_ready, rd_rsp_valid, rd_rsp_err,
        input  rd_rsp_data, pselx, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2: two-way round-robin arbiter; bit 0 is the write port, bit 1 the read port.
module apb_rr_arb2
    import apb_arb_pkg::*;
(
    input  logic       pclk,
    input  logic       preset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output grant_t     lastGnt
);
    assign gnt = (&req) ? ((lastGnt == GNT_RD) ? 2'b01 : 2'b10) : req;

    always_ff @(posedge pclk) begin
        if (preset) lastGnt <= GNT_RD;
        else if (advance) lastGnt <= gnt[1] ? GNT_RD : GNT_WR;
    end
endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin write/read APB4 master sequencer, one transfer outstanding.
// Define APB_ARB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT cycles.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input logic pclk,
    input logic preset,
    apb_master_arb_if.master bus
);
    if (DATAWIDTH % 8 != 0 || TIMEOUT < 2) begin : gBadParam
        $error("apb_master_arb: DATAWIDTH must be a multiple of 8 and TIMEOUT at least 2");
    end

    state_t                 state, nextState;
    grant_t                 lastGnt;
    logic [1:0]             req, gnt;
    logic                   advance, isWrite, rspReady, done, timedOut, errQ;
    logic [ADDRWIDTH-1:0]   addrQ;
    logic [DATAWIDTH-1:0]   wdataQ, rdataQ;
    logic [DATAWIDTH/8-1:0] strbQ;
    logic [2:0]             protQ;

    assign req     = {bus.rd_req_valid, bus.wr_req_valid};
    assign advance = (state == IDLE) && (|req);
    // The arbiter's pointer doubles as the direction of the in-flight transfer.
    assign isWrite  = (lastGnt == GNT_WR);
    assign rspReady = isWrite ? bus.wr_rsp_ready : bus.rd_rsp_ready;
    assign done     = (state == ACCESS) && (bus.pready || timedOut);

    apb_rr_arb2 uArb (.pclk(pclk), .preset(preset), .req(req), .advance(advance), .gnt(gnt), .lastGnt(lastGnt));

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] accessCnt;
    always_ff @(posedge pclk) begin
        if (preset || state == SETUP) accessCnt <= '0;
        else if (state == ACCESS) accessCnt <= accessCnt + CW'(1);
    end
    assign timedOut = (state == ACCESS) && !bus.pready && (accessCnt == CW'(TIMEOUT - 1));
`else
    assign timedOut = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = advance ? SETUP : IDLE;
            SETUP:   nextState = ACCESS;
            ACCESS:  nextState = done ? RESP : ACCESS;
            RESP:    nextState = rspReady ? IDLE : RESP;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            addrQ  <= '0;
            wdataQ <= '0;
            strbQ  <= '0;
            protQ  <= '0;
            errQ   <= 1'b0;
            rdataQ <= '0;
        end else begin
            if (advance) begin
                addrQ  <= gnt[0] ? bus.wr_addr : bus.rd_addr;
                wdataQ <= gnt[0] ? bus.wr_data : '0;
                strbQ  <= gnt[0] ? bus.wr_strb : '0;
                protQ  <= gnt[0] ? bus.wr_prot : bus.rd_prot;
            end
            if (done) begin
                errQ   <= !bus.pready || bus.pslverr;
                rdataQ <= (bus.pready && !bus.pslverr && !isWrite) ? bus.prdata : '0;
            end
        end
    end

    assign bus.wr_req_ready = (state == IDLE) && gnt[0];
    assign bus.rd_req_ready = (state == IDLE) && gnt[1];
    assign bus.pselx        = (state == SETUP) || (state == ACCESS);
    assign bus.penable      = (state == ACCESS);
    assign bus.pwrite       = isWrite;
    assign bus.paddr        = addrQ;
    assign bus.pwdata       = wdataQ;
    assign bus.pstrb        = strbQ;
    assign bus.pprot        = protQ;
    assign bus.wr_rsp_valid = (state == RESP) && isWrite;
    assign bus.rd_rsp_valid = (state == RESP) && !isWrite;
    assign bus.wr_rsp_err   = errQ && isWrite;
    assign bus.rd_rsp_err   = errQ && !isWrite;
    assign bus.rd_rsp_data  = rdataQ;
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: scenario tasks with a response scoreboard for apb_master_arb.
module tb_apb_master_arb;
    import apb_arb_pkg::*;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int errors = 0;
    int checks = 0;
    exp_t expQ[$];
    exp_t e;

    apb_master_arb_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();
    apb_master_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(16)) dut (.pclk(pclk), .preset(preset), .bus(bus));

    always #5 pclk = ~pclk;

    task automatic idle_inputs;
        bus.wr_req_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0; bus.wr_prot = '0;
        bus.rd_req_valid = 0; bus.rd_addr = '0; bus.rd_prot = '0;
        bus.wr_rsp_ready = 0; bus.rd_rsp_ready = 0;
        bus.pready = 0; bus.pslverr = 0; bus.prdata = '0;
    endtask

    task automatic pop_exp;
        if (expQ.size() == 0) begin
            e = '{wr: 1'bx, data: 'x, err: 1'bx};
        end else e = expQ.pop_front();
    endtask

    task automatic test_reset;
        preset = 1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        checks++;
        if ({bus.pselx, bus.penable, bus.pwrite, bus.wr_rsp_valid, bus.rd_rsp_valid, bus.wr_rsp_err, bus.rd_rsp_err} !== 7'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b want 0", {bus.pselx, bus.penable, bus.pwrite, bus.wr_rsp_valid, bus.rd_rsp_valid, bus.wr_rsp_err, bus.rd_rsp_err}); end
        checks++;
        if ({bus.paddr, bus.pwdata, bus.pstrb, bus.pprot, bus.rd_rsp_data} !== '0)
            begin errors++; $display("FAIL reset_data: got %h want 0", {bus.paddr, bus.pwdata, bus.pstrb, bus.pprot, bus.rd_rsp_data}); end
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
        checks++;
        if (dut.uArb.lastGnt !== GNT_RD) begin errors++; $display("FAIL reset_lastgnt: got %0d want GNT_RD", dut.uArb.lastGnt); end
        preset = 0;
    endtask

    task automatic test_write;
        @(negedge pclk);
        bus.wr_addr = 32'h1000; bus.wr_data = 32'hDEADBEEF; bus.wr_strb = 4'hF; bus.wr_prot = 3'b010;
        bus.wr_req_valid = 1; bus.wr_rsp_ready = 1; bus.pready = 1;
        expQ.push_back('{wr: 1'b1, data: '0, err: 1'b0});
        #1;
        checks++;
        if ({bus.wr_req_ready, bus.rd_req_ready, bus.pselx} !== 3'b100)
            begin errors++; $display("FAIL wr_accept: got %b want 100", {bus.wr_req_ready, bus.rd_req_ready, bus.pselx}); end
        @(negedge pclk);
        bus.wr_req_valid = 0;
        checks++;
        if ({bus.pselx, bus.penable, bus.wr_req_ready} !== 3'b100)
            begin errors++; $display("FAIL wr_setup: got %b want 100", {bus.pselx, bus.penable, bus.wr_req_ready}); end
        @(negedge pclk);
        checks++;
        if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot} !== {3'b111, 32'h1000, 32'hDEADBEEF, 4'hF, 3'b010})
            begin errors++; $display("FAIL wr_access: got %b %h %h %h %b", {bus.pselx, bus.penable, bus.pwrite}, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot); end
        @(negedge pclk);
        pop_exp();
        checks++;
        if ({bus.wr_rsp_valid, bus.rd_rsp_valid, bus.wr_rsp_err, bus.pselx} !== {e.wr, !e.wr, e.err, 1'b0})
            begin errors++; $display("FAIL wr_resp: got %b want %b", {bus.wr_rsp_valid, bus.rd_rsp_valid, bus.wr_rsp_err, bus.pselx}, {e.wr, !e.wr, e.err, 1'b0}); end
        @(negedge pclk);
        bus.pready = 0;
        checks++;
        if (bus.wr_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_drop: got %b want 0", bus.wr_rsp_valid); end
    endtask

    task automatic test_read_wait;
        int penCnt = 0;
        int badStrb = 0;
        @(negedge pclk);
        bus.rd_addr = 32'h2004; bus.rd_prot = 3'b000; bus.rd_req_valid = 1; bus.rd_rsp_ready = 1;
        bus.pready = 0; bus.prdata = 32'hFFFFFFFF;
        expQ.push_back('{wr: 1'b0, data: 32'h12345678, err: 1'b0});
        #1;
        checks++;
        if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b10)
            begin errors++; $display("FAIL rd_accept: got %b want 10", {bus.rd_req_ready, bus.wr_req_ready}); end
        @(negedge pclk);
        bus.rd_req_valid = 0;
        checks++;
        if ({bus.pselx, bus.penable, bus.pwrite, bus.pstrb, bus.paddr} !== {3'b100, 4'h0, 32'h2004})
            begin errors++; $display("FAIL rd_setup: got %b %h %h", {bus.pselx, bus.penable, bus.pwrite}, bus.pstrb, bus.paddr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (bus.penable) penCnt++;
            if (bus.pstrb !== 4'h0 || bus.pwdata !== '0 || bus.rd_rsp_valid) badStrb++;
            if (i == 3) begin bus.pready = 1; bus.prdata = 32'h12345678; end
        end
        checks++;
        if (penCnt != 4 || badStrb != 0) begin errors++; $display("FAIL rd_wait: got penable=%0d bad=%0d want 4 0", penCnt, badStrb); end
        @(negedge pclk);
        bus.pready = 0; bus.prdata = 32'hA5A5A5A5;
        pop_exp();
        checks++;
        if ({bus.rd_rsp_valid, bus.wr_rsp_valid, bus.rd_rsp_err, bus.rd_rsp_data, bus.penable} !== {!e.wr, e.wr, e.err, e.data, 1'b0})
            begin errors++; $display("FAIL rd_resp: got %b data %h want data %h", {bus.rd_rsp_valid, bus.wr_rsp_valid, bus.rd_rsp_err}, bus.rd_rsp_data, e.data); end
        @(negedge pclk);
        checks++;
        if ({bus.rd_rsp_valid, bus.rd_rsp_data} !== {1'b0, 32'h12345678})
            begin errors++; $display("FAIL rd_hold_data: got %b %h want 0 12345678", bus.rd_rsp_valid, bus.rd_rsp_data); end
    endtask

    task automatic test_round_robin;
        grant_t order[4] = '{GNT_RD, GNT_RD, GNT_RD, GNT_RD};
        int n = 0, wrLeft = 2, rdLeft = 2, wrPulses = 0, rdPulses = 0, bad = 0, rspBad = 0;
        logic prevWr = 0, prevRd = 0;
        preset = 1;
        @(posedge pclk);
        @(negedge pclk);
        preset = 0;
        bus.pready = 1; bus.pslverr = 0; bus.prdata = 32'h0000BEEF;
        bus.wr_rsp_ready = 1; bus.rd_rsp_ready = 1;
        bus.wr_addr = 32'h3000; bus.wr_data = 32'h11112222; bus.wr_strb = 4'h3; bus.rd_addr = 32'h3004;
        for (int cyc = 0; cyc < 40 && (n < 4 || expQ.size() > 0); cyc++) begin
            bus.wr_req_valid = (wrLeft > 0);
            bus.rd_req_valid = (rdLeft > 0);
            #1;
            if (bus.wr_req_ready && bus.rd_req_ready) bad++;
            if ((prevWr && bus.wr_req_ready) || (prevRd && bus.rd_req_ready)) bad++;
            prevWr = bus.wr_req_ready;
            prevRd = bus.rd_req_ready;
            if (bus.wr_req_ready && n < 4) begin
                order[n] = GNT_WR; n++; wrLeft--; wrPulses++;
                expQ.push_back('{wr: 1'b1, data: '0, err: 1'b0});
            end else if (bus.rd_req_ready && n < 4) begin
                order[n] = GNT_RD; n++; rdLeft--; rdPulses++;
                expQ.push_back('{wr: 1'b0, data: 32'h0000BEEF, err: 1'b0});
            end
            if (bus.wr_rsp_valid || bus.rd_rsp_valid) begin
                pop_exp();
                if ({bus.wr_rsp_valid, bus.rd_rsp_valid, e.wr ? bus.wr_rsp_err : bus.rd_rsp_err, e.wr ? 32'h0 : bus.rd_rsp_data}
                    !== {e.wr, !e.wr, e.err, e.data}) rspBad++;
            end
            @(negedge pclk);
        end
        bus.wr_req_valid = 0; bus.rd_req_valid = 0; bus.pready = 0;
        checks++;
        if ({order[0], order[1], order[2], order[3]} !== {GNT_WR, GNT_RD, GNT_WR, GNT_RD})
            begin errors++; $display("FAIL rr_order: got %b want 0101", {order[0], order[1], order[2], order[3]}); end
        checks++;
        if (wrPulses != 2 || rdPulses != 2 || bad != 0)
            begin errors++; $display("FAIL rr_pulses: got wr=%0d rd=%0d bad=%0d want 2 2 0", wrPulses, rdPulses, bad); end
        checks++;
        if (rspBad != 0 || expQ.size() != 0)
            begin errors++; $display("FAIL rr_resp: got bad=%0d pending=%0d want 0 0", rspBad, expQ.size()); end
    endtask

    task automatic test_err_hold;
        int held = 0, setups = 0;
        @(negedge pclk);
        bus.rd_addr = 32'h4000; bus.rd_prot = 3'b001; bus.rd_req_valid = 1; bus.rd_rsp_ready = 0;
        bus.pready = 1; bus.pslverr = 1; bus.prdata = 32'hCAFEF00D;
        expQ.push_back('{wr: 1'b0, data: '0, err: 1'b1});
        @(negedge pclk);
        bus.rd_req_valid = 0;
        bus.wr_addr = 32'h5000; bus.wr_data = 32'h55AA55AA; bus.wr_strb = 4'hC; bus.wr_prot = 3'b000;
        bus.wr_req_valid = 1; bus.wr_rsp_ready = 1;
        @(negedge pclk);
        pop_exp();
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if ({bus.rd_rsp_valid, bus.rd_rsp_err, bus.rd_rsp_data} === {1'b1, e.err, e.data}) held++;
            if (bus.pselx || bus.wr_req_ready) setups++;
        end
        bus.rd_rsp_ready = 1; bus.pslverr = 0;
        checks++;
        if (held != 5) begin errors++; $display("FAIL err_hold: got %0d cycles want 5", held); end
        checks++;
        if (setups != 0) begin errors++; $display("FAIL err_no_setup: got %0d want 0", setups); end
        @(negedge pclk);
        checks++;
        if ({bus.rd_rsp_valid, bus.wr_req_ready} !== 2'b01)
            begin errors++; $display("FAIL err_release: got %b want 01", {bus.rd_rsp_valid, bus.wr_req_ready}); end
        expQ.push_back('{wr: 1'b1, data: '0, err: 1'b0});
        @(negedge pclk);
        bus.wr_req_valid = 0;
        repeat (2) @(negedge pclk);
        pop_exp();
        checks++;
        if ({bus.wr_rsp_valid, bus.wr_rsp_err} !== {e.wr, e.err})
            begin errors++; $display("FAIL err_next_wr: got %b want %b", {bus.wr_rsp_valid, bus.wr_rsp_err}, {e.wr, e.err}); end
        bus.pready = 0;
        @(negedge pclk);
    endtask

    task automatic test_reset_mid;
        @(negedge pclk);
        bus.wr_addr = 32'h6000; bus.wr_req_valid = 1; bus.pready = 0;
        @(negedge pclk);
        bus.wr_req_valid = 0;
        @(negedge pclk);
        checks++;
        if (bus.penable !== 1'b1) begin errors++; $display("FAIL mid_access: got penable %b want 1", bus.penable); end
        preset = 1;
        @(negedge pclk);
        checks++;
        if ({bus.pselx, bus.penable, bus.wr_rsp_valid, bus.rd_rsp_valid} !== 4'b0 || dut.state !== IDLE)
            begin errors++; $display("FAIL mid_reset: got %b state %0d want 0000 IDLE", {bus.pselx, bus.penable, bus.wr_rsp_valid, bus.rd_rsp_valid}, dut.state); end
        preset = 0;
        @(negedge pclk);
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int acc = 0;
        @(negedge pclk);
        bus.rd_addr = 32'h7000; bus.rd_req_valid = 1; bus.rd_rsp_ready = 0; bus.pready = 0; bus.prdata = 32'hFFFF0000;
        expQ.push_back('{wr: 1'b0, data: '0, err: 1'b1});
        @(negedge pclk);
        bus.rd_req_valid = 0;
        for (int i = 0; i < 40 && !bus.rd_rsp_valid; i++) begin
            @(negedge pclk);
            if (bus.penable) acc++;
        end
        checks++;
        if (acc != 16) begin errors++; $display("FAIL to_cycles: got %0d want 16", acc); end
        pop_exp();
        checks++;
        if ({bus.rd_rsp_valid, bus.rd_rsp_err, bus.rd_rsp_data, bus.pselx} !== {1'b1, e.err, e.data, 1'b0})
            begin errors++; $display("FAIL to_resp: got %b data %h want 11 data %h", {bus.rd_rsp_valid, bus.rd_rsp_err}, bus.rd_rsp_data, e.data); end
        bus.rd_rsp_ready = 1;
        @(negedge pclk);
    endtask
`else
    task automatic test_no_timeout;
        int acc = 0;
        @(negedge pclk);
        bus.rd_addr = 32'h7000; bus.rd_req_valid = 1; bus.rd_rsp_ready = 1; bus.pready = 0; bus.prdata = 32'hFFFF0000;
        expQ.push_back('{wr: 1'b0, data: 32'h0BADF00D, err: 1'b0});
        @(negedge pclk);
        bus.rd_req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (bus.penable && !bus.rd_rsp_valid) acc++;
        end
        checks++;
        if (acc != 20) begin errors++; $display("FAIL wait_forever: got %0d want 20", acc); end
        bus.pready = 1; bus.prdata = 32'h0BADF00D;
        @(negedge pclk);
        bus.pready = 0;
        pop_exp();
        checks++;
        if ({bus.rd_rsp_valid, bus.rd_rsp_err, bus.rd_rsp_data} !== {1'b1, e.err, e.data})
            begin errors++; $display("FAIL wait_resp: got %b data %h want data %h", {bus.rd_rsp_valid, bus.rd_rsp_err}, bus.rd_rsp_data, e.data); end
        @(negedge pclk);
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_write();
        test_read_wait();
        test_round_robin();
        test_err_hold();
        test_reset_mid();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
